// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder with valid/ready stream handshake
// Optional subtract/overflow support: define CLA_PIPE_ADD_SUB_EN.
module cla_pipe_adder #(
  parameter int N   = 32,
  parameter int BLK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
`ifdef CLA_PIPE_ADD_SUB_EN
  input  logic         Sub,
  output logic         Ovf,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  localparam int STAGES = (BLK > 0 && N >= BLK) ? N / BLK : 1;

  if (BLK < 1 || N < BLK || ((BLK > 0) ? (N % BLK) : 1) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: N must be a non-zero multiple of BLK");
  end

  // One lookahead slice: every carry is a flat sum of products of g/p terms and
  // the slice carry-in, so no carry ripples from bit to bit inside the slice.
  function automatic logic [BLK:0] cla_slice(input logic [BLK-1:0] a,
                                             input logic [BLK-1:0] b,
                                             input logic           cin);
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           term;
    g = a & b;
    p = a ^ b;
    c = '0;
    for (int i = 0; i <= BLK; i++) begin
      term = cin;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return {c[BLK], p ^ c[BLK-1:0]};
  endfunction

  logic [N-1:0] b_eff;
  logic         cin_eff;

  // Subtraction is folded into the add at the front: invert B and force carry-in.
  always_comb begin
    b_eff   = B;
    cin_eff = Cin;
`ifdef CLA_PIPE_ADD_SUB_EN
    if (Sub) begin
      b_eff   = ~B;
      cin_eff = 1'b1;
    end
`endif
  end

  // Stage k adds slice k and registers the sum so far, the carry into slice k+1
  // and the operand bits that later slices still need.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM = N - k * BLK;

    logic [REM-1:0]         a_in;
    logic [REM-1:0]         b_in;
    logic                   c_in;
    logic                   v_in;
    logic                   rdy;
    logic                   nxt_rdy;
    logic [BLK:0]           res;
    logic [(k+1)*BLK-1:0]   sum_d;
    logic                   v_q;
    logic                   c_q;
    logic [(k+1)*BLK-1:0]   sum_q;

    if (k == 0) begin : g_src
      assign a_in  = A;
      assign b_in  = b_eff;
      assign c_in  = cin_eff;
      assign v_in  = in_valid;
      assign sum_d = res[BLK-1:0];
    end else begin : g_src
      assign a_in  = g_st[k-1].g_rem.a_q;
      assign b_in  = g_st[k-1].g_rem.b_q;
      assign c_in  = g_st[k-1].c_q;
      assign v_in  = g_st[k-1].v_q;
      assign sum_d = {res[BLK-1:0], g_st[k-1].sum_q};
    end

    if (k == STAGES - 1) begin : g_down
      assign nxt_rdy = out_ready;
    end else begin : g_down
      assign nxt_rdy = g_st[k+1].rdy;
    end

    assign res = cla_slice(a_in[BLK-1:0], b_in[BLK-1:0], c_in);
    // An empty stage always accepts, so bubbles collapse behind a stall.
    assign rdy = !v_q || nxt_rdy;

    // Stage register: valid follows upstream when ready; data only loads with a real beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (rdy) begin
        v_q <= v_in;
        if (v_in) begin
          sum_q <= sum_d;
          c_q   <= res[BLK];
        end
      end
    end

    if (REM > BLK) begin : g_rem
      logic [REM-BLK-1:0] a_q;
      logic [REM-BLK-1:0] b_q;

      // Carry the not-yet-added operand bits forward alongside the beat.
      always_ff @(posedge clk) begin
        if (rdy && v_in) begin
          a_q <= a_in[REM-1:BLK];
          b_q <= b_in[REM-1:BLK];
        end
      end
    end

`ifdef CLA_PIPE_ADD_SUB_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;
      logic ovf_d;

      // Signed overflow: operand signs agree but the result sign differs.
      assign ovf_d = (a_in[BLK-1] == b_in[BLK-1]) && (res[BLK-1] != a_in[BLK-1]);

      // Overflow flag travels with the final stage so it lines up with Sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (rdy && v_in) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign in_ready  = g_st[0].rdy;
  assign out_valid = g_st[STAGES-1].v_q;
  assign Sum       = g_st[STAGES-1].sum_q;
  assign Cout      = g_st[STAGES-1].c_q;
`ifdef CLA_PIPE_ADD_SUB_EN
  assign Ovf       = g_st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed self-checking bench for cla_pipe_adder
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Sum;
  logic        Cout;
`ifdef CLA_PIPE_ADD_SUB_EN
  logic        Sub;
  logic        Ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  cla_pipe_adder #(.N(32), .BLK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef CLA_PIPE_ADD_SUB_EN
    .Sub       (Sub),
    .Ovf       (Ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int recv;
    int last_emit;
    int burst;
    int seen;

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef CLA_PIPE_ADD_SUB_EN
    Sub = 1'b0;
`endif

    // Reset then idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);

    // Single beat, latency 4
    drive(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    #1;
    check("single_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("single_not_early", out_valid, 0);
    tick();
    check("single_out_valid", out_valid, 1);
    check("single_sum", Sum, 32'h0000_0100);
    check("single_cout", Cout, 0);
    tick();
    check("single_one_beat", out_valid, 0);

    // Full carry chain, three beats back to back
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    tick();
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    tick();
    drive(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("carry1_valid", out_valid, 1);
    check("carry1_sum", Sum, 32'h0);
    check("carry1_cout", Cout, 1);
    tick();
    check("carry2_valid", out_valid, 1);
    check("carry2_sum", Sum, 32'h0);
    check("carry2_cout", Cout, 1);
    tick();
    check("carry3_valid", out_valid, 1);
    check("carry3_sum", Sum, 32'h2222_2222);
    check("carry3_cout", Cout, 0);
    tick();
    check("carry_drained", out_valid, 0);

    // Backpressure: 8 beats A=i, B=2i, consumer stalls in cycles 6..9
    sent      = 0;
    recv      = 0;
    last_emit = -1;
    burst     = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      drive(sent < 8, 32'(sent), 32'(2 * sent), 1'b0);
      out_ready = !(cyc >= 6 && cyc <= 9);
      #1;
      if (cyc == 5) check("bp_in_ready_before_stall", in_ready, 1);
      if (cyc == 6) check("bp_in_ready_full", in_ready, 0);
      if (out_valid && !out_ready) check("bp_stall_hold", Sum, 32'd6);
      if (out_valid && out_ready) begin
        check("bp_sum", Sum, 32'(3 * recv));
        check("bp_cout", Cout, 0);
        recv++;
        last_emit = cyc;
        if (cyc >= 10 && cyc <= 15) burst++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_all_received", recv, 8);
    check("bp_last_emit_cycle", last_emit, 15);
    check("bp_full_rate_after_stall", burst, 6);
    tick();
    check("bp_drained", out_valid, 0);

    // Reset mid-flight discards in-flight beats
    drive(1'b1, 32'd1, 32'd1, 1'b0);
    tick();
    drive(1'b1, 32'd2, 32'd2, 1'b0);
    tick();
    drive(1'b1, 32'd3, 32'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst_nothing_emitted", seen, 0);
    drive(1'b1, 32'd5, 32'd7, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("postrst_not_early", out_valid, 0);
    tick();
    check("postrst_valid", out_valid, 1);
    check("postrst_sum", Sum, 32'd12);
    check("postrst_cout", Cout, 0);
    tick();

`ifdef CLA_PIPE_ADD_SUB_EN
    // Subtract and signed overflow
    drive(1'b1, 32'd3, 32'd5, 1'b0);
    Sub = 1'b1;
    tick();
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    Sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("sub_valid", out_valid, 1);
    check("sub_sum", Sum, 32'hFFFF_FFFE);
    check("sub_cout", Cout, 0);
    check("sub_ovf", Ovf, 0);
    tick();
    check("ovf_valid", out_valid, 1);
    check("ovf_sum", Sum, 32'h8000_0000);
    check("ovf_cout", Cout, 0);
    check("ovf_flag", Ovf, 1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
